// File: rtl/spi_xfer_sequencer_if.sv
// Host-side valid/ready byte streams of the SPI transfer sequencer.
// The master modport is the host; the slave modport is the sequencer.
interface spi_xfer_sequencer_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_data;

  modport master (
    output tx_valid, tx_data, rx_ready,
    input  tx_ready, rx_valid, rx_data
  );

  modport slave (
    input  tx_valid, tx_data, rx_ready,
    output tx_ready, rx_valid, rx_data
  );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// Byte-stream front end for an 8-bit SPI master driver: TX/RX FIFOs plus a
// launch/complete/capture FSM that supervises each transfer with timeouts.
module spi_xfer_sequencer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  spi_xfer_sequencer_if.slave      host,
  output logic [$clog2(DEPTH):0]   o_tx_level,
  output logic [$clog2(DEPTH):0]   o_rx_level,
  output logic                     o_spi_start,
  output logic [7:0]               o_spi_tx_data,
  input  logic                     i_spi_busy,
  input  logic [7:0]               i_spi_rx_data,
  output logic                     o_timeout_err,
  input  logic                     i_err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LAUNCH    = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_CAPTURE   = 3'd4;

  localparam logic [AW:0]   LVL_ONE    = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_ZERO   = (AW + 1)'(0);
  localparam logic [AW:0]   LVL_FULL   = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  // 15 busy samples in WAIT_BUSY: counts 0..14
  localparam logic [CW-1:0] BUSY_LIMIT = CW'(14);
  localparam logic [CW-1:0] DONE_LIMIT = CW'(TIMEOUT - 1);

  logic [7:0]    r_tx_mem [DEPTH];
  logic [7:0]    r_rx_mem [DEPTH];
  logic [AW:0]   r_tx_wr_ptr, r_tx_rd_ptr, r_tx_level;
  logic [AW:0]   r_rx_wr_ptr, r_rx_rd_ptr, r_rx_level;
  logic          r_tx_ready, r_rx_valid;
  logic [7:0]    r_rx_data;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_spi_start;
  logic [7:0]    r_spi_tx_data;
  logic          r_timeout_err;

  logic          w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic          w_busy_to, w_done_to;
  logic [AW:0]   w_tx_level_nxt, w_rx_level_nxt, w_rx_rd_ptr_nxt;
  logic [7:0]    w_rx_head_nxt;

  assign w_tx_push = host.tx_valid && r_tx_ready;
  assign w_tx_pop  = (r_state == S_IDLE) && (r_tx_level != LVL_ZERO) && (r_rx_level != LVL_FULL);
  assign w_rx_push = (r_state == S_CAPTURE);
  assign w_rx_pop  = r_rx_valid && host.rx_ready;
  assign w_busy_to = (r_state == S_WAIT_BUSY) && !i_spi_busy && (r_cnt == BUSY_LIMIT);
  assign w_done_to = (r_state == S_WAIT_DONE) && i_spi_busy && (r_cnt == DONE_LIMIT);

  // Next occupancy and RX head; the head register sees a push into an empty FIFO
  always_comb begin
    w_tx_level_nxt  = r_tx_level;
    w_rx_level_nxt  = r_rx_level;
    w_rx_rd_ptr_nxt = r_rx_rd_ptr;
    w_rx_head_nxt   = r_rx_data;
    if (w_tx_push && !w_tx_pop) begin
      w_tx_level_nxt = r_tx_level + LVL_ONE;
    end else if (!w_tx_push && w_tx_pop) begin
      w_tx_level_nxt = r_tx_level - LVL_ONE;
    end else begin
      w_tx_level_nxt = r_tx_level;
    end
    if (w_rx_push && !w_rx_pop) begin
      w_rx_level_nxt = r_rx_level + LVL_ONE;
    end else if (!w_rx_push && w_rx_pop) begin
      w_rx_level_nxt = r_rx_level - LVL_ONE;
    end else begin
      w_rx_level_nxt = r_rx_level;
    end
    if (w_rx_pop) begin
      w_rx_rd_ptr_nxt = r_rx_rd_ptr + LVL_ONE;
    end else begin
      w_rx_rd_ptr_nxt = r_rx_rd_ptr;
    end
    if (w_rx_push && (r_rx_wr_ptr[AW-1:0] == w_rx_rd_ptr_nxt[AW-1:0])) begin
      w_rx_head_nxt = i_spi_rx_data;
    end else begin
      w_rx_head_nxt = r_rx_mem[w_rx_rd_ptr_nxt[AW-1:0]];
    end
  end

  // FIFO storage writes
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr_ptr[AW-1:0]] <= host.tx_data;
    if (w_rx_push) r_rx_mem[r_rx_wr_ptr[AW-1:0]] <= i_spi_rx_data;
  end

  // FIFO pointers, levels and registered stream flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wr_ptr <= LVL_ZERO;
      r_tx_rd_ptr <= LVL_ZERO;
      r_tx_level  <= LVL_ZERO;
      r_tx_ready  <= 1'b1;
      r_rx_wr_ptr <= LVL_ZERO;
      r_rx_rd_ptr <= LVL_ZERO;
      r_rx_level  <= LVL_ZERO;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= 8'h00;
    end else begin
      if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + LVL_ONE;
      if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + LVL_ONE;
      if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + LVL_ONE;
      r_rx_rd_ptr <= w_rx_rd_ptr_nxt;
      r_tx_level  <= w_tx_level_nxt;
      r_rx_level  <= w_rx_level_nxt;
      r_tx_ready  <= (w_tx_level_nxt != LVL_FULL);
      r_rx_valid  <= (w_rx_level_nxt != LVL_ZERO);
      r_rx_data   <= w_rx_head_nxt;
    end
  end

  // Transfer sequencing FSM with start handshake and timeouts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= CNT_ZERO;
      r_spi_start   <= 1'b0;
      r_spi_tx_data <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_tx_pop) begin
            r_spi_tx_data <= r_tx_mem[r_tx_rd_ptr[AW-1:0]];
            r_spi_start   <= 1'b1;
            r_state       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_cnt   <= CNT_ZERO;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (i_spi_busy) begin
            r_spi_start <= 1'b0;
            r_cnt       <= CNT_ZERO;
            r_state     <= S_WAIT_DONE;
          end else if (w_busy_to) begin
            r_spi_start <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_WAIT_DONE: begin
          if (!i_spi_busy) begin
            r_state <= S_CAPTURE;
          end else if (w_done_to) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_CAPTURE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_spi_start <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout_err <= 1'b0;
    end else if (w_busy_to || w_done_to) begin
      r_timeout_err <= 1'b1;
    end else if (i_err_clr) begin
      r_timeout_err <= 1'b0;
    end
  end

  assign host.tx_ready = r_tx_ready;
  assign host.rx_valid = r_rx_valid;
  assign host.rx_data  = r_rx_data;
  assign o_tx_level    = r_tx_level;
  assign o_rx_level    = r_rx_level;
  assign o_spi_start   = r_spi_start;
  assign o_spi_tx_data = r_spi_tx_data;
  assign o_timeout_err = r_timeout_err;

endmodule
